sha3_hasher_arbiter: RTL and testbench

SHA3_HASHER_ARBITER -- requirements
Module: sha3_hasher_arbiter

---
 rtl/sha3_hasher_arbiter.sv | 118 +++++++++++
 tb/tb_sha3_hasher_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_hasher_arbiter.sv
// Round-robin arbiter sharing one pipelined SHA3 hasher among N_REQ scan controllers.
// A tag FIFO remembers who sent each item so in-order results can be routed back.
module sha3_hasher_arbiter_port #(
   parameter int PORT = 0,
   parameter int TW   = 1
) (
   input  logic          xfer,
   input  logic [TW-1:0] gnt,
   input  logic          pop,
   input  logic [TW-1:0] tag,
   output logic          ready,
   output logic          good
);
   assign ready = xfer & (gnt == TW'(PORT));
   assign good  = pop  & (tag == TW'(PORT));
endmodule

module sha3_hasher_arbiter #(
   parameter int N_REQ        = 2,
   parameter int MAX_INFLIGHT = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N_REQ-1:0]                 req_feedgood,
   input  logic [N_REQ-1:0][24:0][63:0]     req_feed,
   output logic [N_REQ-1:0]                 req_ready,
   output logic [N_REQ-1:0]                 res_good,
   output logic [24:0][63:0]                res_hash,
   input  logic                             hasher_ready,
   output logic                             feedgood,
   output logic [24:0][63:0]                feed,
   input  logic                             hashgood,
   input  logic [24:0][63:0]                hash,
   output logic [$clog2(MAX_INFLIGHT):0]    inflight,
   output logic [31:0]                      dispatched,
   output logic                             orphan
);
   localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int AW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int CW = $clog2(MAX_INFLIGHT) + 1;

   logic [TW-1:0] rr_ptr;
   logic [TW-1:0] gnt;
   logic          gnt_vld;
   logic [TW:0]   idx;
   logic          full, empty, xfer, pop;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [TW-1:0] tags [MAX_INFLIGHT];
   logic [TW-1:0] head_tag;

   // Scan downward so the requester closest above rr_ptr is the last (winning) match.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + (TW+1)'(k);
         if (idx >= (TW+1)'(N_REQ))
            idx = idx - (TW+1)'(N_REQ);
         if (req_feedgood[idx[TW-1:0]]) begin
            gnt     = idx[TW-1:0];
            gnt_vld = 1'b1;
         end
      end
   end

   assign full     = (inflight == CW'(MAX_INFLIGHT));
   assign empty    = (inflight == '0);
   // rst gates the handshakes so they drop immediately, not at the next edge.
   assign feedgood = gnt_vld & ~full & ~rst;
   assign xfer     = feedgood & hasher_ready;
   assign feed     = gnt_vld ? req_feed[gnt] : '0;
   assign pop      = hashgood & ~empty & ~rst;
   assign head_tag = tags[rd_ptr];
   assign res_hash = hash;

   for (genvar i = 0; i < N_REQ; i++) begin : g_port
      sha3_hasher_arbiter_port #(.PORT(i), .TW(TW)) u_port (
         .xfer  (xfer),
         .gnt   (gnt),
         .pop   (pop),
         .tag   (head_tag),
         .ready (req_ready[i]),
         .good  (res_good[i])
      );
   end

   always_ff @(posedge clk) begin
      if (xfer)
         tags[wr_ptr] <= gnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         inflight   <= '0;
         dispatched <= '0;
         orphan     <= 1'b0;
      end else begin
         if (xfer) begin
            wr_ptr     <= (wr_ptr == AW'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr + AW'(1);
            rr_ptr     <= (gnt == TW'(N_REQ - 1)) ? '0 : gnt + TW'(1);
            dispatched <= dispatched + 32'd1;
         end
         if (pop)
            rd_ptr <= (rd_ptr == AW'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr + AW'(1);
         case ({xfer, pop})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
         if (hashgood && empty)
            orphan <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sha3_hasher_arbiter.sv
// Bench for sha3_hasher_arbiter: queue-based reference of grants, tag order and a
// latency-modelled hasher; directed scenarios plus a randomized soak.
module tb_sha3_hasher_arbiter;
   logic                       clk = 1'b0;
   logic                       rst;
   logic [1:0]                 req_feedgood;
   logic [1:0][24:0][63:0]     req_feed;
   logic                       hasher_ready, hashgood;
   logic [24:0][63:0]          hash;

   logic [1:0]        req_ready, res_good;
   logic [24:0][63:0] res_hash, feed;
   logic              feedgood, orphan;
   logic [3:0]        inflight;
   logic [31:0]       dispatched;

   logic [1:0]        req_ready4, res_good4;
   logic [24:0][63:0] res_hash4, feed4;
   logic              feedgood4, orphan4;
   logic [2:0]        inflight4;
   logic [31:0]       dispatched4;

   sha3_hasher_arbiter #(.N_REQ(2), .MAX_INFLIGHT(8)) dut (
      .clk(clk), .rst(rst), .req_feedgood(req_feedgood), .req_feed(req_feed),
      .req_ready(req_ready), .res_good(res_good), .res_hash(res_hash),
      .hasher_ready(hasher_ready), .feedgood(feedgood), .feed(feed),
      .hashgood(hashgood), .hash(hash), .inflight(inflight),
      .dispatched(dispatched), .orphan(orphan));

   sha3_hasher_arbiter #(.N_REQ(2), .MAX_INFLIGHT(4)) dut4 (
      .clk(clk), .rst(rst), .req_feedgood(req_feedgood), .req_feed(req_feed),
      .req_ready(req_ready4), .res_good(res_good4), .res_hash(res_hash4),
      .hasher_ready(hasher_ready), .feedgood(feedgood4), .feed(feed4),
      .hashgood(hashgood), .hash(hash), .inflight(inflight4),
      .dispatched(dispatched4), .orphan(orphan4));

   initial forever #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model state
   int              m_max = 8;
   int              rr, cyc, disp, lat_lo, lat_hi, last_due;
   bit              orph;
   int              tagq[$];
   logic [1599:0]   tq_h[$];
   logic [1599:0]   hq_d[$];
   int              hq_due[$];
   // per-cycle expectations
   int              e_g;
   bit              e_fg, e_xfer, e_pop, e_hqpop;
   logic [1:0]      e_ready, e_good;
   logic [1599:0]   e_feed, e_hash;
   int              e_infl;

   function automatic logic [1599:0] hfun(input logic [1599:0] x);
      return {x[1598:0], x[1599]} ^ {25{64'h9E37_79B9_7F4A_7C15}};
   endfunction

   function automatic logic [1599:0] rnd1600();
      logic [1599:0] r;
      for (int i = 0; i < 50; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_clear();
      rr = 0; cyc = 0; disp = 0; orph = 0; last_due = 0;
      tagq.delete(); tq_h.delete(); hq_d.delete(); hq_due.delete();
   endtask

   task automatic apply_reset();
      rst = 1'b1; req_feedgood = '0; hasher_ready = 1'b0; hashgood = 1'b0;
      hash = '0; req_feed = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_clear();
   endtask

   // hmode: 0 = hasher silent, 1 = hasher returns when due, 2 = force one hashgood pulse
   task automatic drive(input logic [1:0] offer, input bit hrdy, input int hmode);
      bit full;
      req_feedgood = offer;
      hasher_ready = hrdy;
      req_feed[0] = rnd1600();
      req_feed[1] = rnd1600();
      hashgood = 1'b0;
      hash = rnd1600();
      e_hqpop = 0;
      if (hmode == 1 && hq_due.size() > 0 && hq_due[0] <= cyc) begin
         hashgood = 1'b1; hash = hq_d[0]; e_hqpop = 1;
      end else if (hmode == 2) begin
         hashgood = 1'b1;
         if (hq_d.size() > 0) begin hash = hq_d[0]; e_hqpop = 1; end
      end
      e_g = -1;
      for (int k = 0; k < 2; k++)
         if (e_g < 0 && offer[(rr + k) % 2]) e_g = (rr + k) % 2;
      full    = (tagq.size() == m_max);
      e_fg    = (e_g >= 0) && !full;
      e_xfer  = e_fg && hrdy;
      e_ready = e_xfer ? 2'(1 << e_g) : 2'b00;
      e_feed  = (e_g >= 0) ? req_feed[e_g] : '0;
      e_pop   = hashgood && (tagq.size() > 0);
      e_good  = e_pop ? 2'(1 << tagq[0]) : 2'b00;
      e_hash  = e_pop ? tq_h[0] : '0;
      e_infl  = tagq.size();
      #2;
   endtask

   task automatic finish_cycle();
      int due;
      if (e_xfer) begin
         tagq.push_back(e_g);
         tq_h.push_back(hfun(e_feed));
         hq_d.push_back(hfun(e_feed));
         due = cyc + $urandom_range(lat_hi, lat_lo);
         if (due < last_due) due = last_due;
         last_due = due;
         hq_due.push_back(due);
         rr = (e_g + 1) % 2;
         disp++;
      end
      if (e_hqpop) begin void'(hq_d.pop_front()); void'(hq_due.pop_front()); end
      if (e_pop) begin void'(tagq.pop_front()); void'(tq_h.pop_front()); end
      if (hashgood && !e_pop) orph = 1;
      @(posedge clk);
      #1 cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_feedgood = 2'b11; hasher_ready = 1'b1; hashgood = 1'b1;
      hash = '0; req_feed = '0;
      #3;
      n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
      n_cmp++; if (feedgood !== 1'b0) begin n_fail++; $display("FAIL rst_feedgood got=%b exp=0", feedgood); end
      n_cmp++; if (res_good !== 2'b00) begin n_fail++; $display("FAIL rst_res_good got=%b exp=00", res_good); end
      @(posedge clk); #1;
      n_cmp++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL rst_inflight got=%0d exp=0", inflight); end
      n_cmp++; if (dispatched !== 32'd0) begin n_fail++; $display("FAIL rst_dispatched got=%0d exp=0", dispatched); end
      n_cmp++; if (orphan !== 1'b0) begin n_fail++; $display("FAIL rst_orphan got=%b exp=0", orphan); end
      apply_reset();
   endtask

   task automatic test_alternate();
      logic [1:0] want;
      apply_reset();
      lat_lo = 1; lat_hi = 1;
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, 1'b1, 0);
         want = (k % 2 == 0) ? 2'b01 : 2'b10;
         n_cmp++; if (req_ready !== want) begin n_fail++; $display("FAIL alt_ready k=%0d got=%b exp=%b", k, req_ready, want); end
         n_cmp++; if (feed !== e_feed) begin n_fail++; $display("FAIL alt_feed k=%0d got=%h exp=%h", k, feed[0], e_feed[63:0]); end
         finish_cycle();
      end
      n_cmp++; if (dispatched !== 32'd4) begin n_fail++; $display("FAIL alt_dispatched got=%0d exp=4", dispatched); end
   endtask

   task automatic test_single();
      apply_reset();
      lat_lo = 3; lat_hi = 3;
      for (int k = 0; k < 10; k++) begin
         drive(2'b10, 1'b1, 1);
         n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL single_ready k=%0d got=%b exp=10", k, req_ready); end
         n_cmp++; if (res_good !== e_good) begin n_fail++; $display("FAIL single_res_good k=%0d got=%b exp=%b", k, res_good, e_good); end
         finish_cycle();
      end
      drive(2'b11, 1'b1, 1);
      n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_rr_back got=%b exp=01", req_ready); end
      finish_cycle();
   endtask

   task automatic test_tags();
      logic [1:0] offers [4];
      logic [1:0] want [4];
      logic [1:0] got [$];
      offers = '{2'b11, 2'b11, 2'b10, 2'b01};
      want   = '{2'b01, 2'b10, 2'b10, 2'b01};
      apply_reset();
      lat_lo = 24; lat_hi = 24;
      for (int k = 0; k < 4; k++) begin
         drive(offers[k], 1'b1, 1);
         n_cmp++; if (req_ready !== want[k]) begin n_fail++; $display("FAIL tags_ready k=%0d got=%b exp=%b", k, req_ready, want[k]); end
         finish_cycle();
      end
      for (int k = 0; k < 40; k++) begin
         drive(2'b00, 1'b0, 1);
         if (res_good !== 2'b00) begin
            got.push_back(res_good);
            n_cmp++; if (res_hash !== e_hash) begin n_fail++; $display("FAIL tags_hash k=%0d got=%h exp=%h", k, res_hash[0], e_hash[63:0]); end
         end
         finish_cycle();
      end
      n_cmp++; if (got.size() != 4) begin n_fail++; $display("FAIL tags_count got=%0d exp=4", got.size()); end
      for (int k = 0; k < 4 && k < got.size(); k++) begin
         n_cmp++; if (got[k] !== want[k]) begin n_fail++; $display("FAIL tags_seq k=%0d got=%b exp=%b", k, got[k], want[k]); end
      end
   endtask

   task automatic test_full();
      apply_reset();
      m_max = 4; lat_lo = 1; lat_hi = 1;
      for (int k = 0; k < 6; k++) begin
         drive(2'b11, 1'b1, 0);
         n_cmp++; if (req_ready4 !== e_ready) begin n_fail++; $display("FAIL full_ready k=%0d got=%b exp=%b", k, req_ready4, e_ready); end
         if (k >= 4) begin
            n_cmp++; if (feedgood4 !== 1'b0) begin n_fail++; $display("FAIL full_feedgood k=%0d got=%b exp=0", k, feedgood4); end
         end
         finish_cycle();
      end
      n_cmp++; if (inflight4 !== 3'd4) begin n_fail++; $display("FAIL full_inflight got=%0d exp=4", inflight4); end
      drive(2'b11, 1'b1, 2);
      n_cmp++; if (req_ready4 !== 2'b00) begin n_fail++; $display("FAIL full_pop_ready got=%b exp=00", req_ready4); end
      n_cmp++; if (res_good4 !== 2'b01) begin n_fail++; $display("FAIL full_pop_good got=%b exp=01", res_good4); end
      finish_cycle();
      drive(2'b11, 1'b1, 0);
      n_cmp++; if (req_ready4 !== e_ready || e_ready == 2'b00) begin n_fail++; $display("FAIL full_refill got=%b exp=%b", req_ready4, e_ready); end
      finish_cycle();
      n_cmp++; if (inflight4 !== 3'd4) begin n_fail++; $display("FAIL full_inflight2 got=%0d exp=4", inflight4); end
      m_max = 8;
   endtask

   task automatic test_orphan();
      apply_reset();
      lat_lo = 2; lat_hi = 2;
      drive(2'b00, 1'b0, 2);
      n_cmp++; if (res_good !== 2'b00) begin n_fail++; $display("FAIL orphan_good got=%b exp=00", res_good); end
      finish_cycle();
      for (int k = 0; k < 6; k++) begin
         drive(2'b11, 1'b1, 1);
         n_cmp++; if (orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky k=%0d got=%b exp=1", k, orphan); end
         n_cmp++; if (res_good !== e_good) begin n_fail++; $display("FAIL orphan_res_good k=%0d got=%b exp=%b", k, res_good, e_good); end
         finish_cycle();
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      lat_lo = 1; lat_hi = 1;
      for (int k = 0; k < 5; k++) begin
         drive(2'b11, 1'b1, 0);
         finish_cycle();
      end
      n_cmp++; if (inflight !== 4'd5) begin n_fail++; $display("FAIL mid_inflight_pre got=%0d exp=5", inflight); end
      req_feedgood = 2'b11; hasher_ready = 1'b1; hashgood = 1'b1;
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_ready got=%b exp=00", req_ready); end
      n_cmp++; if (feedgood !== 1'b0) begin n_fail++; $display("FAIL mid_feedgood got=%b exp=0", feedgood); end
      n_cmp++; if (res_good !== 2'b00) begin n_fail++; $display("FAIL mid_res_good got=%b exp=00", res_good); end
      n_cmp++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL mid_inflight got=%0d exp=0", inflight); end
      @(negedge clk);
      hashgood = 1'b0; req_feedgood = 2'b00;
      rst = 1'b0;
      model_clear();
      @(posedge clk); #1;
      drive(2'b00, 1'b0, 2);
      n_cmp++; if (res_good !== 2'b00) begin n_fail++; $display("FAIL mid_late_good got=%b exp=00", res_good); end
      finish_cycle();
      drive(2'b11, 1'b1, 0);
      n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_first_grant got=%b exp=01", req_ready); end
      n_cmp++; if (orphan !== 1'b1) begin n_fail++; $display("FAIL mid_orphan got=%b exp=1", orphan); end
      finish_cycle();
   endtask

   task automatic test_random();
      apply_reset();
      lat_lo = 1; lat_hi = 20;
      for (int k = 0; k < 400; k++) begin
         drive(2'($urandom), ($urandom_range(3, 0) != 0), 1);
         n_cmp++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, req_ready, e_ready); end
         n_cmp++; if (feedgood !== e_fg) begin n_fail++; $display("FAIL rnd_feedgood k=%0d got=%b exp=%b", k, feedgood, e_fg); end
         n_cmp++; if (feed !== e_feed) begin n_fail++; $display("FAIL rnd_feed k=%0d got=%h exp=%h", k, feed[0], e_feed[63:0]); end
         n_cmp++; if (res_good !== e_good) begin n_fail++; $display("FAIL rnd_res_good k=%0d got=%b exp=%b", k, res_good, e_good); end
         if (e_pop) begin
            n_cmp++; if (res_hash !== e_hash) begin n_fail++; $display("FAIL rnd_hash k=%0d got=%h exp=%h", k, res_hash[0], e_hash[63:0]); end
         end
         n_cmp++; if (inflight !== 4'(e_infl)) begin n_fail++; $display("FAIL rnd_inflight k=%0d got=%0d exp=%0d", k, inflight, e_infl); end
         n_cmp++; if (dispatched !== 32'(disp)) begin n_fail++; $display("FAIL rnd_dispatched k=%0d got=%0d exp=%0d", k, dispatched, disp); end
         n_cmp++; if (orphan !== orph) begin n_fail++; $display("FAIL rnd_orphan k=%0d got=%b exp=%b", k, orphan, orph); end
         finish_cycle();
      end
   endtask

   initial begin
      model_clear();
      lat_lo = 1; lat_hi = 1;
      test_reset();
      test_alternate();
      test_single();
      test_tags();
      test_full();
      test_orphan();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
